// File: rtl/snax_csrman_cfgqueue.sv
// snax_csrman_cfgqueue: CSR manager with a CfgDepth-deep configuration queue.
// The core programs staging CSRs over csr_req/csr_rsp; a LAUNCH write to STATUS
// (bit0=1) pushes the staged set into the queue. The accelerator pops it through
// csr_reg_rw_set_o/csr_reg_set_valid_o/csr_reg_set_ready_i.
// csr_reg_ro_set_i carries the accelerator's read-only status values.
// Optional macro SNAX_CSRMAN_PERF_EN adds a saturating busy-cycle counter at idx S+1.
module snax_csrman_cfgqueue #(
   parameter int unsigned NumRwCsr    = 6,
   parameter int unsigned NumRoCsr    = 4,
   parameter int unsigned CfgDepth    = 2,
   parameter logic [31:0] CsrAddrBase = 32'h3c0
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [31:0]                   csr_req_data_i,
   input  logic [31:0]                   csr_req_addr_i,
   input  logic [3:0]                    csr_req_strb_i,
   input  logic                          csr_req_write_i,
   input  logic                          csr_req_valid_i,
   output logic                          csr_req_ready_o,
   output logic [31:0]                   csr_rsp_data_o,
   output logic                          csr_rsp_valid_o,
   input  logic                          csr_rsp_ready_i,
   output logic [NumRwCsr-1:0][31:0]     csr_reg_rw_set_o,
   output logic                          csr_reg_set_valid_o,
   input  logic                          csr_reg_set_ready_i,
   input  logic [NumRoCsr-1:0][31:0]     csr_reg_ro_set_i
);

   localparam int unsigned PtrW = (CfgDepth > 1) ? $clog2(CfgDepth) : 1;
   localparam int unsigned CntW = $clog2(CfgDepth + 1);
   localparam logic [31:0] StatusIdx = 32'(NumRwCsr + NumRoCsr);

   typedef logic [NumRwCsr-1:0][31:0] cfg_t;

   cfg_t            stage_q;
   cfg_t            slot_q [CfgDepth];
   logic [PtrW-1:0] wptr_q;
   logic [PtrW-1:0] rptr_q;
   logic [CntW-1:0] count_q;
   logic [31:0]     rsp_data_q;
   logic            rsp_valid_q;

   logic [31:0] idx;
   logic [31:0] rdata;
   logic        is_status;
   logic        full;
   logic        empty;
   logic        launch;
   logic        req_ready;
   logic        accept;
   logic        push;
   logic        pop;

   function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
      return (p == PtrW'(CfgDepth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign idx       = csr_req_addr_i - CsrAddrBase;
   assign is_status = (idx == StatusIdx);
   assign full      = (count_q == CntW'(CfgDepth));
   assign empty     = (count_q == '0);
   assign launch    = csr_req_write_i && is_status && csr_req_data_i[0];

   // Only a LAUNCH into a full queue is held off; other requests keep flowing.
   assign req_ready = (!rsp_valid_q || csr_rsp_ready_i) && !(launch && full);
   assign accept    = csr_req_valid_i && req_ready;
   assign push      = accept && launch;
   assign pop       = !empty && csr_reg_set_ready_i;

`ifdef SNAX_CSRMAN_PERF_EN
   localparam logic [31:0] PerfIdx = StatusIdx + 32'd1;
   logic [31:0] perf_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_q <= '0;
      end else if (accept && csr_req_write_i && idx == PerfIdx) begin
         perf_q <= '0;
      end else if (!empty && perf_q != '1) begin
         perf_q <= perf_q + 32'd1;
      end
   end
`endif

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NumRwCsr; i++) begin
         if (idx == 32'(i)) rdata = stage_q[i];
      end
      for (int i = 0; i < NumRoCsr; i++) begin
         if (idx == 32'(NumRwCsr + i)) rdata = csr_reg_ro_set_i[i];
      end
      if (is_status) rdata = {14'b0, empty, full, 16'(count_q)};
`ifdef SNAX_CSRMAN_PERF_EN
      if (idx == PerfIdx) rdata = perf_q;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stage_q <= '0;
      end else if (accept && csr_req_write_i) begin
         for (int i = 0; i < NumRwCsr; i++) begin
            for (int b = 0; b < 4; b++) begin
               if (idx == 32'(i) && csr_req_strb_i[b]) begin
                  stage_q[i][8*b +: 8] <= csr_req_data_i[8*b +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int d = 0; d < CfgDepth; d++) slot_q[d] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            slot_q[wptr_q] <= stage_q;
            wptr_q         <= ptr_next(wptr_q);
         end
         if (pop) rptr_q <= ptr_next(rptr_q);
         if (push && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else if (accept && !csr_req_write_i) begin
         rsp_valid_q <= 1'b1;
         rsp_data_q  <= rdata;
      end else if (csr_rsp_ready_i) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign csr_req_ready_o     = req_ready;
   assign csr_rsp_data_o      = rsp_data_q;
   assign csr_rsp_valid_o     = rsp_valid_q;
   assign csr_reg_rw_set_o    = slot_q[rptr_q];
   assign csr_reg_set_valid_o = !empty;

endmodule
